// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: default bus widths and the arbiter state encoding.
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  // Arbiter ownership states; the encoding is fixed so debug tools can decode it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  // One-hot grant vector for a state; IDLE (and any illegal code) owns nothing.
  function automatic logic [1:0] state_to_grant(input arb_state_e st);
    logic [1:0] g;
    g = 2'b00;
    case (st)
      ST_GNT0: g = 2'b01;
      ST_GNT1: g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts consecutive cycles with an outstanding, unacknowledged
// strobe and flags the cycle in which the count reaches TIMEOUT.
// TIMEOUT = 0 disables expiry entirely.
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,     // restart the count (ack seen, strobe low, owner change)
  input  logic stall,   // owner has cyc & stb asserted this cycle
  output logic expire   // this stalled cycle is the TIMEOUT-th in a row
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit;

  // Expiry does not look at clr, so it never depends on the slave ack
  // combinationally; the caller decides whether an ack overrides it.
  always_comb begin
    hit    = (TIMEOUT > 0) && stall && (cnt_q == CNT_LAST);
    expire = hit;
    cnt_d  = cnt_q;
    if (clr || hit) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Saturating stall counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter with round-robin tie-break, locked
// cycles (grant held while the owner keeps cyc high) and a stall timeout.
//
// Handshake: a master requests with cyc & stb; a transfer completes in the
// cycle the slave raises ack while stb is high. The owner keeps the bus for
// as long as its cyc stays high, regardless of stb. ack/err only ever reach
// the current owner; the other master sees them as 0.
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   m0_addr,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [DW/8-1:0] m1_sel,
  input  logic            m0_we,
  input  logic            m1_we,
  input  logic            m0_cyc,
  input  logic            m1_cyc,
  input  logic            m0_stb,
  input  logic            m1_stb,
  output logic [DW-1:0]   m0_rdata,
  output logic [DW-1:0]   m1_rdata,
  output logic            m0_ack,
  output logic            m1_ack,
  output logic            m0_err,
  output logic            m1_err,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_sel,
  output logic            s_we,
  output logic            s_cyc,
  output logic            s_stb,
  input  logic [DW-1:0]   s_rdata,
  input  logic            s_ack,
  output logic [1:0]      grant
);

  arb_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;  // 0 = m0, 1 = m1
  logic       req0, req1;
  logic       own0, own1;
  logic       own_cyc, own_stb;
  logic       wd_stall, wd_clr, wd_expire;

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

  // Next-state: grant from IDLE, hold while the owner's cyc stays high,
  // hand over directly to a waiting master when the owner releases.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_d = last_owner_q ? ST_GNT0 : ST_GNT1;
        end else if (req0) begin
          state_d = ST_GNT0;
        end else if (req1) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc) begin
          last_owner_d = 1'b0;
          state_d      = req1 ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc) begin
          last_owner_d = 1'b1;
          state_d      = req0 ? ST_GNT0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and round-robin history registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Slave-side mux and response routing; IDLE drives an inert request.
  always_comb begin
    own0     = (state_q == ST_GNT0);
    own1     = (state_q == ST_GNT1);
    grant    = state_to_grant(state_q);
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_sel    = '0;
    s_we     = 1'b0;
    if (own0) begin
      own_cyc = m0_cyc;
      own_stb = m0_stb;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_sel   = m0_sel;
      s_we    = m0_we;
    end else if (own1) begin
      own_cyc = m1_cyc;
      own_stb = m1_stb;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_sel   = m1_sel;
      s_we    = m1_we;
    end
    s_cyc    = own_cyc;
    // The strobe is withdrawn in the timeout cycle so the slave sees the
    // transfer abandoned at the same moment the master sees err.
    s_stb    = own_stb & ~wd_expire;
    m0_rdata = s_rdata;
    m1_rdata = s_rdata;
    m0_ack   = own0 & s_ack;
    m1_ack   = own1 & s_ack;
    // A late ack in the expiry cycle wins over the error.
    m0_err   = own0 & wd_expire & ~s_ack;
    m1_err   = own1 & wd_expire & ~s_ack;
  end

  // Watchdog control: count owner cycles with an open strobe, restart on
  // any ack, strobe gap or ownership change.
  always_comb begin
    wd_stall = own_cyc & own_stb;
    wd_clr   = s_ack | ~wd_stall | (state_d != state_q);
  end

  wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (wd_clr),
    .stall  (wd_stall),
    .expire (wd_expire)
  );

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width; the select width is DW/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum stalled cycles before error; 0 disables the timeout.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports m0_addr/m1_addr  input  AW  master address (m0 = instruction, m1 = data).
REQ-007 SHALL have ports m0_wdata/m1_wdata  input  DW  master write data.
REQ-008 SHALL have ports m0_sel/m1_sel  input  DW/8  master byte select.
REQ-009 SHALL have ports m0_we/m1_we, m0_cyc/m1_cyc, m0_stb/m1_stb  input  1 each  master Wishbone classic controls.
REQ-010 SHALL have ports m0_rdata/m1_rdata  output  DW  read data.
REQ-011 SHALL have ports m0_ack/m1_ack  output  1  ack, routed to the granted master only.
REQ-012 SHALL have ports m0_err/m1_err  output  1  timeout error.
REQ-013 SHALL have ports s_addr  AW, s_wdata  DW, s_sel  DW/8, s_we/s_cyc/s_stb  1 each, all outputs  shared slave request.
REQ-014 SHALL have ports s_rdata  input  DW and s_ack  input  1  shared slave response.
REQ-015 SHALL have port grant  output  2  one-hot current owner; 00 when idle.

Function
REQ-016 SHALL implement states IDLE, GNT0, GNT1.
- Request condition: mX_cyc & mX_stb.
REQ-017 SHALL, in IDLE with exactly one request, enter that master's GNT state on the next edge.
REQ-018 SHALL, in IDLE with both requesting, grant the master that did not last own the bus (round-robin); last_owner resets to m1, so m0 wins the first tie.
REQ-019 SHALL drive s_* combinationally from the granted master while in GNTx, and drive s_cyc = s_stb = 0 in IDLE.
- Request-to-slave latency: exactly 1 cycle.
REQ-020 SHALL hold the grant while the owner keeps mX_cyc high, across any number of stb/ack transfers (locked cycle).
REQ-021 SHALL, when the owner drops cyc, record last_owner = X and on the next edge:
- grant the other master if it is requesting;
- otherwise return to IDLE.
REQ-022 SHALL pass s_rdata to both mX_rdata unmodified, and gate s_ack to the owner only; the non-owner's ack and err stay 0.
REQ-023 SHALL ignore s_ack in IDLE.
REQ-024 SHALL count consecutive owner cycles with s_cyc & s_stb & ~s_ack, using a counter of width clog2(TIMEOUT+1) that saturates (never wraps).
- The counter clears on s_ack, on stb low, or on a grant change.
REQ-025 SHALL, when the count reaches TIMEOUT (TIMEOUT > 0), assert mX_err for exactly one cycle, force s_stb low for that cycle, and clear the counter.
REQ-026 SHALL honour s_ack (not err) if s_ack and the timeout occur in the same cycle.

Reset
REQ-027 SHALL, on reset_n low, immediately and asynchronously set:
- state = IDLE, grant = 00, last_owner = m1, counter = 0;
- all mX_ack and mX_err = 0;
- s_cyc = s_stb = 0.
REQ-028 SHALL abandon any in-flight transfer on reset without completing it and without issuing ack or err.
REQ-029 SHALL, on reset release, accept requests starting from the first rising edge with reset_n high.

Structure
REQ-030 SHALL take the state encoding (IDLE = 0, GNT0 = 1, GNT1 = 2) from shared package wb_pkg, alongside the default WB widths.
REQ-031 SHALL place the stall counter in one sub-module, wb_watchdog, with inputs clk, reset_n, clr, stall and output expire (parameter TIMEOUT).
REQ-032 SHALL contain no latches, and every output SHALL be defined in every state.

Verification
REQ-033 SHALL cover: m0 single read, slave acks after 2 cycles -> s_cyc rises 1 cycle after request, m0_ack for 1 cycle, m1_ack = 0, grant = 01.
REQ-034 SHALL cover: m0 and m1 both request immediately after reset -> m0 granted first; m1 granted the cycle after m0 drops cyc, with no IDLE cycle in between.
REQ-035 SHALL cover: m1 holds cyc for 3 back-to-back stb/ack transfers while m0 waits -> grant stays 10 throughout, then moves to 01.
REQ-036 SHALL cover: TIMEOUT = 4, slave never acks -> m0_err pulses 1 cycle at the 4th stall cycle and s_stb is low in that cycle.
REQ-037 SHALL cover: reset_n pulsed low mid-transfer with s_ack arriving later -> no ack to either master, grant = 00 immediately.
REQ-038 SHALL cover: TIMEOUT = 0 with the slave stalled for 1000 cycles -> no err, and the grant is held.
